// File: rtl/calc_pkg.sv
// calc_pkg: key codes, operator encoding and sequencer states
package calc_pkg;
    localparam logic [3:0] KEY_ADD   = 4'd10;
    localparam logic [3:0] KEY_SUB   = 4'd11;
    localparam logic [3:0] KEY_MUL   = 4'd12;
    localparam logic [3:0] KEY_DIV   = 4'd13;
    localparam logic [3:0] KEY_ENTER = 4'd14;
    localparam logic [3:0] KEY_CLEAR = 4'd15;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;
    typedef enum logic [2:0] {S_A, S_B, S_START, S_WAIT, S_SHOW, S_ERR} state_t;
    function automatic logic [1:0] op_of(input logic [3:0] code);
        return 2'(code - KEY_ADD);
    endfunction
endpackage

// File: rtl/calc_entry_ctrl_if.sv
// calc_entry_ctrl_if: keypad, ALU and display signals of the entry sequencer
interface calc_entry_ctrl_if #(parameter int WIDTH = 32);
    logic             key_valid;
    logic [3:0]       key_code;
    logic             alu_done;
    logic [WIDTH-1:0] alu_result;
    logic             alu_err;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [1:0]       op_sel;
    logic             alu_start;
    logic [WIDTH-1:0] disp_value;
    logic             error;
    logic             busy;
    modport master (
        input  key_valid, key_code, alu_done, alu_result, alu_err,
        output op_a, op_b, op_sel, alu_start, disp_value, error, busy
    );
    modport slave (
        output key_valid, key_code, alu_done, alu_result, alu_err,
        input  op_a, op_b, op_sel, alu_start, disp_value, error, busy
    );
endinterface

// File: rtl/key_event_det.sv
// key_event_det: one-cycle event on the rising edge of a held key
module key_event_det (
    input  logic clk,
    input  logic rst_n,
    input  logic key_valid,
    output logic key_evt
);
    logic prev;
    // remember the last key level so a held key fires only once
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) prev <= 1'b0;
        else prev <= key_valid;
    assign key_evt = key_valid & ~prev;
endmodule

// File: rtl/calc_entry_ctrl.sv
// calc_entry_ctrl: keypad events to ALU operands, ALU handshake and display select
module calc_entry_ctrl
    import calc_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MAX_DIGITS = 8
) (
    input logic clk,
    input logic rst_n,
    calc_entry_ctrl_if.master bus
);
    localparam int CW = $clog2(MAX_DIGITS + 1);
    state_t state, state_n;
    logic [WIDTH-1:0] acc, acc_n, op_a, op_a_n, op_b, op_b_n, result, result_n;
    logic [WIDTH+3:0] acc_x;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0] op_sel, op_sel_n;
    logic pend, pend_n, pend_eff, clr, key_evt, is_dig, is_op, is_ent, is_clr;

    key_event_det u_key (.clk(clk), .rst_n(rst_n), .key_valid(bus.key_valid), .key_evt(key_evt));

    assign is_dig   = key_evt && bus.key_code < KEY_ADD;
    assign is_op    = key_evt && bus.key_code >= KEY_ADD && bus.key_code <= KEY_DIV;
    assign is_ent   = key_evt && bus.key_code == KEY_ENTER;
    assign is_clr   = key_evt && bus.key_code == KEY_CLEAR;
    assign acc_x    = {4'd0, acc} * (WIDTH+4)'(10) + (WIDTH+4)'(bus.key_code);
    assign pend_eff = pend || is_clr;

    // next state and next datapath values for each key/ALU event
    always_comb begin
        state_n  = state;
        acc_n    = acc;
        cnt_n    = cnt;
        op_a_n   = op_a;
        op_b_n   = op_b;
        op_sel_n = op_sel;
        result_n = result;
        pend_n   = pend;
        clr      = 1'b0;
        case (state)
            S_A, S_B: begin
                if (is_clr) clr = 1'b1;
                else if (is_dig) begin
                    if (cnt < CW'(MAX_DIGITS)) begin
                        acc_n = acc_x[WIDTH-1:0];
                        cnt_n = cnt + CW'(1);
                    end
                end else if (is_op && state == S_A) begin
                    op_a_n   = acc;
                    op_sel_n = op_of(bus.key_code);
                    acc_n    = '0;
                    cnt_n    = '0;
                    state_n  = S_B;
                end else if (is_op && cnt == '0) op_sel_n = op_of(bus.key_code);
                else if (is_ent && state == S_B) begin
                    op_b_n  = acc;
                    state_n = S_START;
                end
            end
            S_START: state_n = S_WAIT;
            S_WAIT: begin
                if (!bus.alu_done) pend_n = pend_eff;
                else if (pend_eff) clr = 1'b1;
                else if (bus.alu_err) state_n = S_ERR;
                else begin
                    result_n = bus.alu_result;
                    state_n  = S_SHOW;
                end
            end
            S_SHOW: begin
                if (is_clr) clr = 1'b1;
                else if (is_dig) begin
                    acc_n   = WIDTH'(bus.key_code);
                    cnt_n   = CW'(1);
                    state_n = S_A;
                end else if (is_op) begin
                    op_a_n   = result;
                    op_sel_n = op_of(bus.key_code);
                    acc_n    = '0;
                    cnt_n    = '0;
                    state_n  = S_B;
                end
            end
            default: if (is_clr) clr = 1'b1;
        endcase
        if (clr) begin
            state_n  = S_A;
            acc_n    = '0;
            cnt_n    = '0;
            op_a_n   = '0;
            op_b_n   = '0;
            op_sel_n = OP_ADD;
            result_n = '0;
            pend_n   = 1'b0;
        end
    end

    // sequencer state and datapath registers
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state  <= S_A;
            acc    <= '0;
            cnt    <= '0;
            op_a   <= '0;
            op_b   <= '0;
            op_sel <= OP_ADD;
            result <= '0;
            pend   <= 1'b0;
        end else begin
            state  <= state_n;
            acc    <= acc_n;
            cnt    <= cnt_n;
            op_a   <= op_a_n;
            op_b   <= op_b_n;
            op_sel <= op_sel_n;
            result <= result_n;
            pend   <= pend_n;
        end

    assign bus.op_a       = op_a;
    assign bus.op_b       = op_b;
    assign bus.op_sel     = op_sel;
    assign bus.alu_start  = state == S_START;
    assign bus.busy       = state == S_START || state == S_WAIT;
    assign bus.error      = state == S_ERR;
    assign bus.disp_value = state == S_A    ? acc :
                            state == S_B    ? (cnt == '0 ? op_a : acc) :
                            bus.busy        ? op_b :
                            state == S_SHOW ? result : '0;
endmodule

// File: tb/tb_calc_entry_ctrl.sv
// tb_calc_entry_ctrl: directed and random key/ALU traffic against a digit-queue model
module tb_calc_entry_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    calc_entry_ctrl_if #(.WIDTH(32)) bus();
    calc_entry_ctrl #(.WIDTH(32), .MAX_DIGITS(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    localparam int M_A = 0, M_B = 1, M_START = 2, M_WAIT = 3, M_SHOW = 4, M_ERR = 5;
    int n_chk = 0, n_fail = 0;
    int m_mode = M_A;
    int dq[$];
    logic [31:0] m_opa = 0, m_opb = 0, m_res = 0;
    int m_op = 0;
    bit m_pend = 0, m_prev = 0;
    bit auto_alu = 0;
    int cd = 0;

    function automatic logic [31:0] val();
        longint v = 0;
        foreach (dq[i]) v = (v * 10 + dq[i]) & 64'hFFFF_FFFF;
        return v[31:0];
    endfunction

    function automatic void full_clear();
        dq.delete();
        m_opa = 0; m_opb = 0; m_res = 0; m_op = 0; m_pend = 0; m_mode = M_A;
    endfunction

    function automatic logic [31:0] exp_disp();
        if (m_mode == M_A) return val();
        if (m_mode == M_B) return dq.size() == 0 ? m_opa : val();
        if (m_mode == M_START || m_mode == M_WAIT) return m_opb;
        if (m_mode == M_SHOW) return m_res;
        return 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // behavioural model: operands as digit queues, applied on each rising clock edge
    initial forever begin
        bit ev, isd, iso, ise, isc;
        int c;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            full_clear();
            m_prev = 0;
        end else begin
            ev = bus.key_valid && !m_prev;
            c = int'(bus.key_code);
            m_prev = bus.key_valid;
            isd = ev && c < 10;
            iso = ev && c >= 10 && c <= 13;
            ise = ev && c == 14;
            isc = ev && c == 15;
            case (m_mode)
                M_A, M_B: begin
                    if (isc) full_clear();
                    else if (isd) begin
                        if (dq.size() < 8) dq.push_back(c);
                    end else if (iso && m_mode == M_A) begin
                        m_opa = val(); m_op = c - 10; dq.delete(); m_mode = M_B;
                    end else if (iso && dq.size() == 0) m_op = c - 10;
                    else if (ise && m_mode == M_B) begin
                        m_opb = val(); m_mode = M_START;
                    end
                end
                M_START: m_mode = M_WAIT;
                M_WAIT: begin
                    if (isc) m_pend = 1;
                    if (bus.alu_done) begin
                        if (m_pend) full_clear();
                        else if (bus.alu_err) m_mode = M_ERR;
                        else begin m_res = bus.alu_result; m_mode = M_SHOW; end
                    end
                end
                M_SHOW: begin
                    if (isc) full_clear();
                    else if (isd) begin dq.delete(); dq.push_back(c); m_mode = M_A; end
                    else if (iso) begin m_opa = m_res; m_op = c - 10; dq.delete(); m_mode = M_B; end
                end
                default: if (isc) full_clear();
            endcase
        end
    end

    // every-cycle comparison of all outputs against the model
    initial forever begin
        @(posedge clk);
        #2;
        if (rst_n) begin
            chk("op_a", bus.op_a, m_opa);
            chk("op_b", bus.op_b, m_opb);
            chk("op_sel", 32'(bus.op_sel), 32'(m_op));
            chk("alu_start", 32'(bus.alu_start), 32'(m_mode == M_START));
            chk("busy", 32'(bus.busy), 32'(m_mode == M_START || m_mode == M_WAIT));
            chk("error", 32'(bus.error), 32'(m_mode == M_ERR));
            chk("disp_value", bus.disp_value, exp_disp());
        end
    end

    task automatic tick();
        @(negedge clk);
        bus.alu_done = 1'b0;
        if (auto_alu) begin
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    bus.alu_done = 1'b1;
                    bus.alu_result = $urandom;
                    bus.alu_err = ($urandom_range(0, 5) == 0);
                end
            end else if (m_mode == M_START) cd = $urandom_range(1, 4);
            else if ($urandom_range(0, 39) == 0) begin
                bus.alu_done = 1'b1;
                bus.alu_result = $urandom;
                bus.alu_err = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic press(input logic [3:0] c, input int hold = 1, input int gap = 1);
        tick();
        bus.key_valid = 1'b1;
        bus.key_code = c;
        repeat (hold) tick();
        bus.key_valid = 1'b0;
        repeat (gap - 1) tick();
    endtask

    task automatic done(input logic [31:0] r, input logic e);
        tick();
        bus.alu_done = 1'b1;
        bus.alu_result = r;
        bus.alu_err = e;
        tick();
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_op_a"}, bus.op_a, 0);
        chk({nm, "_op_b"}, bus.op_b, 0);
        chk({nm, "_op_sel"}, 32'(bus.op_sel), 0);
        chk({nm, "_start"}, 32'(bus.alu_start), 0);
        chk({nm, "_busy"}, 32'(bus.busy), 0);
        chk({nm, "_error"}, 32'(bus.error), 0);
        chk({nm, "_disp"}, bus.disp_value, 0);
    endtask

    initial begin
        logic [3:0] c;
        int r;
        bus.key_valid = 1'b0; bus.key_code = 4'd0;
        bus.alu_done = 1'b0; bus.alu_result = 0; bus.alu_err = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        // 12 + 34
        press(1); press(2); press(10); press(3); press(4); press(14);
        chk("t1_op_a", bus.op_a, 12);
        chk("t1_op_b", bus.op_b, 34);
        chk("t1_op_sel", 32'(bus.op_sel), 0);
        chk("t1_start", 32'(bus.alu_start), 1);
        chk("t1_model_opb", m_opb, 34);
        tick();
        chk("t1_start_off", 32'(bus.alu_start), 0);
        chk("t1_busy", 32'(bus.busy), 1);
        done(46, 1'b0);
        chk("t1_disp", bus.disp_value, 46);
        chk("t1_model_mode", 32'(m_mode), M_SHOW);
        // chaining 46 * 2
        press(12); press(2); press(14);
        chk("t5_op_a", bus.op_a, 46);
        chk("t5_op_b", bus.op_b, 2);
        chk("t5_op_sel", 32'(bus.op_sel), 2);
        chk("t5_start", 32'(bus.alu_start), 1);
        tick();
        done(92, 1'b0);
        chk("t5_disp", bus.disp_value, 92);
        press(15);
        // nine digits, ninth dropped
        for (int i = 1; i <= 9; i++) press(4'(i));
        chk("t2_disp", bus.disp_value, 12345678);
        press(13);
        chk("t2_op_a", bus.op_a, 12345678);
        chk("t2_model_opa", m_opa, 12345678);
        chk("t2_op_sel", 32'(bus.op_sel), 3);
        press(15);
        // held key, operator overwrite
        press(7, 5);
        chk("t3_disp", bus.disp_value, 7);
        press(10); press(10); press(11);
        chk("t3_op_sel", 32'(bus.op_sel), 1);
        chk("t3_op_a", bus.op_a, 7);
        chk("t3_disp_b", bus.disp_value, 7);
        press(15);
        // divide by zero -> error
        press(8); press(13); press(0); press(14);
        tick();
        done(0, 1'b1);
        chk("t4_error", 32'(bus.error), 1);
        chk("t4_disp", bus.disp_value, 0);
        press(5);
        chk("t4_error_hold", 32'(bus.error), 1);
        press(15);
        chk_zero("t4_clear");
        // CLEAR while waiting discards the result
        press(1); press(10); press(1); press(14);
        tick();
        press(15);
        done(99, 1'b0);
        chk_zero("t6_pend");
        press(3);
        chk("t6_new_a", bus.disp_value, 3);
        press(15);
        // asynchronous reset mid-wait
        press(2); press(10); press(2); press(14);
        tick();
        #2 rst_n = 1'b0;
        #1 chk_zero("t6_rst");
        tick();
        rst_n = 1'b1;
        done(5, 1'b0);
        chk_zero("t6_late_done");
        // randomized traffic
        auto_alu = 1;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            c = r < 50 ? 4'($urandom_range(0, 9)) : r < 75 ? 4'($urandom_range(10, 13)) : r < 92 ? 4'd14 : 4'd15;
            press(c, $urandom_range(1, 3), $urandom_range(1, 3));
        end
        repeat (8) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
